// File: rtl/store_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// store_ctrl_pkg
// Definitions shared by the sample FIFO write side (store_ctrl) and the read
// side (load_ctrl): FSM state encoding, default base address and the helpers
// that derive counter width and per-sample address step from the parameters.
// -----------------------------------------------------------------------------
package store_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Both ends of the FIFO must agree on where a capture starts.
  localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h0000_0000_0000_0000;

  // Width needed to index FIFO_SIZE entries.
  function automatic int size_width(input int fifo_size);
    return $clog2(fifo_size);
  endfunction

  // Byte address increment per sample.
  function automatic int addr_step(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/store_addr_cnt.sv
// -----------------------------------------------------------------------------
// store_addr_cnt
// Sample counter and write-address counter for one capture.
//   clk, rstn  : clock, asynchronous active-low reset
//   load_i     : start of capture; clears count, latches len_i, rewinds address
//   len_i      : capture length (already clamped to the FIFO depth)
//   inc_i      : one sample accepted
//   addr_o     : address of the next sample to be written
//   last_o     : the sample accepted now is the final one of the capture
// -----------------------------------------------------------------------------
module store_addr_cnt
  import store_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    CNT_WIDTH  = 11,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    ADDR_STEP  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load_i,
  input  logic [CNT_WIDTH-1:0]  len_i,
  input  logic                  inc_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  logic [CNT_WIDTH-1:0]  count_q;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      len_q   <= '0;
      addr_q  <= BASE_ADDR;
    end else if (load_i) begin
      count_q <= '0;
      len_q   <= len_i;
      addr_q  <= BASE_ADDR;
    end else if (inc_i) begin
      count_q <= count_q + CNT_WIDTH'(1);
      // Modulo 2^ADDR_WIDTH; len never exceeds the FIFO depth so no wrap logic.
      addr_q  <= addr_q + ADDR_WIDTH'(ADDR_STEP);
    end
  end

  assign addr_o = addr_q;
  assign last_o = (count_q == len_q - CNT_WIDTH'(1));

endmodule

// File: rtl/store_ctrl.sv
// -----------------------------------------------------------------------------
// store_ctrl
// Captures a bounded burst of producer samples into the sample FIFO.
//   clk, rstn              : clock, asynchronous active-low reset
//   start, capture_len     : capture request and its length (0 is rejected,
//                            lengths above FIFO_SIZE are clamped)
//   abort                  : ends an active capture, no done pulse
//   sample_in, sample_vld  : producer sample stream
//   fifo_rdy               : FIFO not full
//   fifo_data, fifo_wr_en  : registered FIFO write port (1-cycle latency)
//   wr_addr                : address of the next sample to be written
//   busy, capture_done     : status (registered from state, one cycle behind)
//   event_*                : one-cycle protocol/overflow pulses
// -----------------------------------------------------------------------------
module store_ctrl
  import store_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = ADDR_WIDTH'(DEFAULT_BASE_ADDR),
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    FIFO_SIZE       = 1024,
  localparam int                   FIFO_SIZE_WIDTH = size_width(FIFO_SIZE),
  localparam int                   ADDR_STEP       = addr_step(DATA_WIDTH)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic                       abort,
  input  logic [FIFO_SIZE_WIDTH:0]   capture_len,
  input  logic [DATA_WIDTH-1:0]      sample_in,
  input  logic                       sample_vld,
  input  logic                       fifo_rdy,
  output logic [DATA_WIDTH-1:0]      fifo_data,
  output logic                       fifo_wr_en,
  output logic [ADDR_WIDTH-1:0]      wr_addr,
  output logic                       busy,
  output logic                       capture_done,
  output logic                       event_overflow,
  output logic                       event_start_while_busy,
  output logic                       event_zero_len_start
);

  localparam int                 CW       = FIFO_SIZE_WIDTH + 1;
  localparam logic [CW-1:0]      MAX_LEN  = CW'(FIFO_SIZE);

  state_e            state_q, state_d;
  logic              in_idle, in_capture;
  logic              load, accept, drop, last;
  logic [CW-1:0]     len_clamped;

  logic [DATA_WIDTH-1:0] fifo_data_q;
  logic                  fifo_wr_en_q, busy_q, done_q;
  logic                  ovf_q, swb_q, zls_q;

  assign in_idle     = (state_q == IDLE);
  assign in_capture  = (state_q == CAPTURE);
  assign load        = in_idle && start && (capture_len != '0);
  // Abort wins over a sample presented in the same cycle.
  assign accept      = in_capture && !abort && sample_vld &&  fifo_rdy;
  assign drop        = in_capture && !abort && sample_vld && !fifo_rdy;
  assign len_clamped = (capture_len > MAX_LEN) ? MAX_LEN : capture_len;

  store_addr_cnt #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CW),
    .BASE_ADDR  (BASE_ADDR),
    .ADDR_STEP  (ADDR_STEP)
  ) u_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .load_i (load),
    .len_i  (len_clamped),
    .inc_i  (accept),
    .addr_o (wr_addr),
    .last_o (last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = CAPTURE;
      CAPTURE: begin
        if (abort)               state_d = IDLE;
        else if (accept && last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers. Status flags follow the state register one cycle late,
  // so capture_done and the falling busy appear together after the last write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifo_data_q  <= '0;
      fifo_wr_en_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      swb_q        <= 1'b0;
      zls_q        <= 1'b0;
    end else begin
      fifo_wr_en_q <= accept;
      if (accept) fifo_data_q <= sample_in;
      busy_q       <= in_capture;
      done_q       <= (state_q == DONE);
      ovf_q        <= drop;
      swb_q        <= in_capture && start;
      zls_q        <= in_idle && start && (capture_len == '0);
    end
  end

  assign fifo_data              = fifo_data_q;
  assign fifo_wr_en             = fifo_wr_en_q;
  assign busy                   = busy_q;
  assign capture_done           = done_q;
  assign event_overflow         = ovf_q;
  assign event_start_while_busy = swb_q;
  assign event_zero_len_start   = zls_q;

endmodule

// File: tb/tb_store_ctrl.sv
// -----------------------------------------------------------------------------
// tb_store_ctrl
// Directed scenarios plus randomized traffic against a transaction-level
// reference model (remaining-sample countdown, expected address/data).
// -----------------------------------------------------------------------------
module tb_store_ctrl;

  localparam int FIFO_SIZE = 1024;
  localparam int CW        = 11;
  localparam int STEP      = 4;
  localparam logic [63:0] BASE = 64'h0;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0, abort = 1'b0, sample_vld = 1'b0, fifo_rdy = 1'b0;
  logic [CW-1:0] capture_len = '0;
  logic [31:0]   sample_in = '0;
  logic [31:0]   fifo_data;
  logic          fifo_wr_en, busy, capture_done;
  logic          event_overflow, event_start_while_busy, event_zero_len_start;
  logic [63:0]   wr_addr;

  store_ctrl dut (
    .clk                    (clk),
    .rstn                   (rstn),
    .start                  (start),
    .abort                  (abort),
    .capture_len            (capture_len),
    .sample_in              (sample_in),
    .sample_vld             (sample_vld),
    .fifo_rdy               (fifo_rdy),
    .fifo_data              (fifo_data),
    .fifo_wr_en             (fifo_wr_en),
    .wr_addr                (wr_addr),
    .busy                   (busy),
    .capture_done           (capture_done),
    .event_overflow         (event_overflow),
    .event_start_while_busy (event_start_while_busy),
    .event_zero_len_start   (event_zero_len_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_capturing, m_finishing;
  int          m_left;
  logic [63:0] m_addr;
  bit          e_wr, e_busy, e_done, e_ovf, e_swb, e_zls;
  logic [31:0] e_data;

  int obs_wr, obs_ovf, obs_done, obs_swb, obs_zls;

  function automatic void model_reset();
    m_capturing = 0; m_finishing = 0; m_left = 0; m_addr = BASE;
    e_wr = 0; e_busy = 0; e_done = 0; e_ovf = 0; e_swb = 0; e_zls = 0; e_data = '0;
  endfunction

  // Called at each rising edge with the inputs the DUT just sampled.
  function automatic void model_step();
    e_wr = 0; e_ovf = 0; e_swb = 0; e_zls = 0;
    e_busy = m_capturing;
    e_done = m_finishing;
    if (m_finishing) begin
      m_finishing = 0;
    end else if (m_capturing) begin
      if (start) e_swb = 1;
      if (abort) m_capturing = 0;
      else if (sample_vld && fifo_rdy) begin
        e_wr = 1; e_data = sample_in;
        m_addr = m_addr + STEP;
        m_left--;
        if (m_left == 0) begin m_capturing = 0; m_finishing = 1; end
      end else if (sample_vld) e_ovf = 1;
    end else if (start) begin
      if (capture_len == 0) e_zls = 1;
      else begin
        m_capturing = 1;
        m_left = (int'(capture_len) > FIFO_SIZE) ? FIFO_SIZE : int'(capture_len);
        m_addr = BASE;
      end
    end
  endfunction

  task automatic compare_outputs();
    check("wr_en", 64'(fifo_wr_en), 64'(e_wr));
    if (e_wr) check("data", 64'(fifo_data), 64'(e_data));
    check("addr", wr_addr, m_addr);
    check("busy", 64'(busy), 64'(e_busy));
    check("done", 64'(capture_done), 64'(e_done));
    check("ovf", 64'(event_overflow), 64'(e_ovf));
    check("swb", 64'(event_start_while_busy), 64'(e_swb));
    check("zls", 64'(event_zero_len_start), 64'(e_zls));
    obs_wr   += int'(fifo_wr_en);
    obs_ovf  += int'(event_overflow);
    obs_done += int'(capture_done);
    obs_swb  += int'(event_start_while_busy);
    obs_zls  += int'(event_zero_len_start);
  endtask

  task automatic drive(input logic s, input logic a, input int len,
                       input logic v, input logic [31:0] d, input logic r);
    start = s; abort = a; capture_len = CW'(len);
    sample_vld = v; sample_in = d; fifo_rdy = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 32'h0, 1);
  endtask

  task automatic clear_obs();
    obs_wr = 0; obs_ovf = 0; obs_done = 0; obs_swb = 0; obs_zls = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr_en"}, 64'(fifo_wr_en), 64'd0);
    check({tag, "_data"},  64'(fifo_data), 64'd0);
    check({tag, "_addr"},  wr_addr, BASE);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_done"},  64'(capture_done), 64'd0);
    check({tag, "_evts"},  64'({event_overflow, event_start_while_busy, event_zero_len_start}), 64'd0);
  endtask

  initial begin
    model_reset();
    clear_obs();
    repeat (2) @(negedge clk);
    check_reset_values("por");
    #2 rstn = 1'b1;

    // Basic capture of 4 samples A0..A3.
    clear_obs();
    drive(1, 0, 4, 0, 32'h0, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 32'hA0 + 32'(i), 1);
    idle(3);
    check("basic_writes", 64'(obs_wr), 64'd4);
    check("basic_done", 64'(obs_done), 64'd1);
    check("basic_addr", wr_addr, BASE + 64'd16);

    // Backpressure: FIFO full on the 2nd sample.
    clear_obs();
    drive(1, 0, 3, 0, 32'h0, 1);
    drive(0, 0, 0, 1, 32'hB0, 1);
    drive(0, 0, 0, 1, 32'hB1, 0);
    drive(0, 0, 0, 1, 32'hB2, 1);
    drive(0, 0, 0, 1, 32'hB3, 1);
    idle(3);
    check("bp_writes", 64'(obs_wr), 64'd3);
    check("bp_ovf", 64'(obs_ovf), 64'd1);
    check("bp_addr", wr_addr, BASE + 64'd12);

    // Start while busy, then zero-length start.
    clear_obs();
    drive(1, 0, 5, 0, 32'h0, 1);
    drive(0, 0, 0, 1, 32'hC0, 1);
    drive(0, 0, 0, 1, 32'hC1, 1);
    drive(1, 0, 1, 0, 32'h0, 1);
    for (int i = 2; i < 5; i++) drive(0, 0, 0, 1, 32'hC0 + 32'(i), 1);
    idle(3);
    drive(1, 0, 0, 0, 32'h0, 1);
    idle(2);
    check("proto_swb", 64'(obs_swb), 64'd1);
    check("proto_writes", 64'(obs_wr), 64'd5);
    check("proto_zls", 64'(obs_zls), 64'd1);
    check("proto_busy_idle", 64'(busy), 64'd0);

    // Abort after 2 of 8, sample presented in the abort cycle.
    clear_obs();
    drive(1, 0, 8, 0, 32'h0, 1);
    drive(0, 0, 0, 1, 32'hD0, 1);
    drive(0, 0, 0, 1, 32'hD1, 1);
    drive(0, 1, 0, 1, 32'hD2, 1);
    drive(0, 0, 0, 1, 32'hD3, 1);
    idle(3);
    check("abort_writes", 64'(obs_wr), 64'd2);
    check("abort_done", 64'(obs_done), 64'd0);

    // Length clamp: FIFO_SIZE+5 requested.
    clear_obs();
    drive(1, 0, FIFO_SIZE + 5, 0, 32'h0, 1);
    for (int i = 0; i < FIFO_SIZE + 5; i++) drive(0, 0, 0, 1, 32'h1000 + 32'(i), 1);
    idle(3);
    check("clamp_writes", 64'(obs_wr), 64'(FIFO_SIZE));
    check("clamp_addr", wr_addr, BASE + 64'(FIFO_SIZE * STEP));
    check("clamp_done", 64'(obs_done), 64'd1);

    // Async reset between edges in the middle of a capture.
    drive(1, 0, 6, 0, 32'h0, 1);
    drive(0, 0, 0, 1, 32'hE0, 1);
    drive(0, 0, 0, 1, 32'hE1, 1);
    #3 rstn = 1'b0;
    #1 check_reset_values("arst");
    model_reset();
    start = 0; sample_vld = 0; abort = 0;
    @(negedge clk);
    #2 rstn = 1'b1;
    clear_obs();
    drive(1, 0, 2, 0, 32'h0, 1);
    drive(0, 0, 0, 1, 32'hF0, 1);
    drive(0, 0, 0, 1, 32'hF1, 1);
    idle(3);
    check("post_rst_writes", 64'(obs_wr), 64'd2);
    check("post_rst_done", 64'(obs_done), 64'd1);
    check("post_rst_addr", wr_addr, BASE + 64'd8);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0),
            int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
            $urandom, ($urandom_range(0, 4) != 0));
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
